t_counter: RTL and testbench
============================

Name: t_counter

Overview:
- Clear-controlled cycle timer, used as the timing element of the button debouncer.
- While `clear` is low it counts `clk` cycles and raises `done` once N cycles have elapsed.
- `done` stays high, saturated, until `clear` or reset.
- The debouncer holds `clear` high when idle and releases it to time how long a button input stays stable.

Parameters:
- N, default 50: number of `clk` cycles with `clear` low before `done` asserts. Legal range is N >= 1; elaborate-time error if N < 1.
- W (localparam), value $clog2(N+1): width of the count register, sized to hold the value N.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_l, input, 1: synchronous reset, active-high. Asserted when 1, sampled only on the rising edge of `clk`. The name is kept from the codebase; the polarity is fixed as active-high.
- clear, input, 1: synchronous clear, active-high. While 1, holds the counter at 0 and `done` at 0.
- done, output, 1: registered terminal flag. 1 when count == N.
- count, output, W: current elapsed-cycle count, registered, range 0..N.

Behaviour:
- All logic is synchronous to the rising edge of `clk`; no asynchronous paths.
- Priority per edge is reset, then clear, then count.
- Reset: on an edge with rst_l == 1, count <= 0 and done <= 0. Both outputs are 0 from the first edge of reset onward, regardless of `clear`.
- Clear: on an edge with rst_l == 0 and clear == 1, count <= 0 and done <= 0.
- Count: on an edge with rst_l == 0 and clear == 0:
  - if count < N, then count <= count + 1;
  - if count == N, count holds at N (saturates; no wrap-around).
- done:
  - Registered; done <= 1 on the same edge at which count becomes N, i.e. when count_next == N.
  - Equivalently, done == (count == N) at all times.
  - done is never combinationally dependent on `clear`.
- Latency: after `clear` is first sampled low, done rises at the N-th consecutive rising edge with clear == 0. With N = 1, done rises at the first such edge.
- Clear mid-count: any single edge with clear == 1 discards progress. Counting restarts from 0 on the next edge with clear == 0.
- Clear while done == 1: done drops and count returns to 0 on that edge.
- Reset mid-operation: same effect as clear.
- Once done == 1 with clear held low, count stays at N and done stays 1 indefinitely.
- Initial values (simulation/FPGA init): count = 0, done = 0.
- No X propagation: outputs are defined after the first reset edge even if `clear` is X. Reset has priority.
- Size is small; implementation may add assertions for count <= N and done == (count == N) inside translate_off regions.

Test Plan:
- Reset: N = 5; hold rst_l = 1 for 3 edges with clear = 0 -> count = 0 and done = 0 throughout; release, then after 5 edges with clear = 0 -> count = 5, done = 1.
- Nominal timing: N = 5; rst_l = 0; clear = 1 for 2 edges, then 0 -> count steps 1,2,3,4,5 on successive edges; done is 0 after edges 1–4 and 1 after edge 5.
- Saturation: N = 5; keep clear = 0 for 20 edges after done rises -> count stays 5, done stays 1, no wrap to 0.
- Clear mid-count: N = 5; pulse clear = 1 for one edge when count = 3 -> count = 0 and done = 0 next edge; done re-rises exactly 5 edges after clear returns low.
- Clear and reset priority: N = 5; with done = 1, assert clear = 1 -> done = 0 and count = 0 on that edge; assert rst_l = 1 and clear = 0 together -> count = 0, done = 0.
- Default and edge parameter: N = 50 -> done rises at the 50th edge after clear low (count = 50, W = 6); N = 1 -> done rises at the first edge with clear = 0.

Source files
------------

// File: rtl/t_counter.sv
// t_counter: clear-controlled cycle timer for the button debouncer.
// Counts clk edges while clear is low and saturates at N, raising done on the
// edge where the count reaches N. Reset (rst_l, active-high) and clear both
// zero the state synchronously, with reset taking priority.
module t_counter #(
    parameter int N = 50,
    localparam int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         clear,
    output logic         done,
    output logic [W-1:0] count
);

    // Terminal value at the register width
    localparam logic [W-1:0] CountMax = W'(N);

    // Elaboration-time guard on the legal parameter range
    if (N < 1) begin : g_bad_n
        $error("t_counter: N must be >= 1");
    end

    logic [W-1:0] count_next;

    // Next count: reset wins over clear, clear wins over counting; saturate at N
    always_comb begin
        count_next = count;
        if (rst_l) begin
            count_next = '0;
        end else if (clear) begin
            count_next = '0;
        end else if (count != CountMax) begin
            count_next = count + 1'b1;
        end
    end

    // State update; done is registered from the next count so it tracks count == N
    always_ff @(posedge clk) begin
        count <= count_next;
        done  <= (count_next == CountMax);
    end

`ifndef SYNTHESIS
    // Invariants: count never exceeds N, and done mirrors count == N
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            assert (count <= CountMax)
                else $error("t_counter: count above N");
            assert (done == (count == CountMax))
                else $error("t_counter: done out of step with count");
        end
    end
`endif

endmodule

// File: tb/tb_t_counter.sv
// tb_t_counter: drives three timers (N = 5, 50, 1) from a shared rst_l/clear
// and compares them after every edge against a run-length model: the number of
// consecutive edges with reset and clear both low since the last reset/clear.
module tb_t_counter;

    logic clk;
    logic rst_l;
    logic clear;

    logic       done5;
    logic [2:0] count5;
    logic       done50;
    logic [5:0] count50;
    logic       done1;
    logic [0:0] count1;

    int checks = 0;
    int errors = 0;
    int run    = 0;

    t_counter #(.N(5)) u_dut5 (
        .clk   (clk),
        .rst_l (rst_l),
        .clear (clear),
        .done  (done5),
        .count (count5)
    );

    t_counter #(.N(50)) u_dut50 (
        .clk   (clk),
        .rst_l (rst_l),
        .clear (clear),
        .done  (done50),
        .count (count50)
    );

    t_counter #(.N(1)) u_dut1 (
        .clk   (clk),
        .rst_l (rst_l),
        .clear (clear),
        .done  (done1),
        .count (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected values derived from the run length alone
    function automatic int exp_count(input int n);
        return (run < n) ? run : n;
    endfunction

    function automatic int exp_done(input int n);
        return (run >= n) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, " count5"},  int'(count5),  exp_count(5));
        check({tag, " done5"},   int'(done5),   exp_done(5));
        check({tag, " count50"}, int'(count50), exp_count(50));
        check({tag, " done50"},  int'(done50),  exp_done(50));
        check({tag, " count1"},  int'(count1),  exp_count(1));
        check({tag, " done1"},   int'(done1),   exp_done(1));
    endtask

    // One rising edge with the current inputs, model update, then sample
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_l || clear) run = 0;
        else if (run < 1000) run++;
        #1;
        check_all(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst_l = 1'b1;
        clear = 1'b0;
        #2;

        // Reset held with clear low: everything stays at zero
        steps("reset", 3);
        check("reset_direct count5", int'(count5), 0);

        // Release: N=5 reaches done on the 5th edge, N=1 on the 1st
        rst_l = 1'b0;
        step("post_reset");
        check("n1_first_edge done1", int'(done1), 1);
        steps("post_reset", 3);
        check("before_5th done5", int'(done5), 0);
        step("post_reset");
        check("at_5th count5", int'(count5), 5);
        check("at_5th done5", int'(done5), 1);

        // Saturation for 20 edges
        steps("saturate", 20);
        check("saturated count5", int'(count5), 5);

        // Nominal timing after a two-edge clear
        clear = 1'b1;
        steps("clear2", 2);
        clear = 1'b0;
        steps("nominal", 3);
        check("mid count5", int'(count5), 3);

        // Clear pulse at count 3 discards progress
        clear = 1'b1;
        step("clear_mid");
        check("clear_mid done5", int'(done5), 0);
        clear = 1'b0;
        steps("restart", 4);
        check("restart_4 done5", int'(done5), 0);
        step("restart");
        check("restart_5 done5", int'(done5), 1);

        // N=50 needs 50 edges; 5 already elapsed
        steps("long", 44);
        check("long_49 done50", int'(done50), 0);
        step("long");
        check("long_50 count50", int'(count50), 50);
        check("long_50 done50", int'(done50), 1);
        steps("long_sat", 5);

        // Clear while done drops everything on that edge
        clear = 1'b1;
        step("clear_done");
        check("clear_done count50", int'(count50), 0);
        clear = 1'b0;
        steps("recount", 6);

        // Reset with clear low behaves like clear
        rst_l = 1'b1;
        step("reset_mid");
        check("reset_mid done5", int'(done5), 0);
        // Reset wins over clear in any combination
        clear = 1'b1;
        step("reset_clear");
        rst_l = 1'b0;
        clear = 1'b0;

        // Randomized phase: sparse clears/resets so the long timer also saturates
        for (int i = 0; i < 3000; i++) begin
            rst_l = ($urandom_range(0, 199) == 0);
            if (i % 1000 < 300) clear = ($urandom_range(0, 3) == 0);
            else                clear = ($urandom_range(0, 89) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
